// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// A byte is accepted over valid/ready and handed to the transmitter with a
// one-cycle start pulse. The frame is then followed through the transmitter's
// busy flag, with a timeout on busy rising. A guaranteed idle gap separates
// frames.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [8*N_REQ-1:0]       i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [7:0]               o_tx_data,
    input  logic                     i_tx_busy,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_active,
    output logic                     o_err
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [7:0]       TMO_INIT  = 8'(BUSY_TIMEOUT);
    localparam logic [7:0]       GAP_INIT  = 8'(GAP_CYCLES);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(N_REQ - 1);
    localparam logic [IDW:0]     N_W       = (IDW + 1)'(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT   = {{(N_REQ - 1){1'b0}}, 1'b1};

    // Parameters outside their legal ranges stop elaboration.
    generate
        if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
            $error("uart_tx_arbiter: N_REQ must be within 2..16");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
            $error("uart_tx_arbiter: GAP_CYCLES must be within 0..255");
        end
        if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_bad_tmo
            $error("uart_tx_arbiter: BUSY_TIMEOUT must be within 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   grant_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             active_q;
    logic             err_q;
    logic [7:0]       tmo_cnt_q;
    logic [7:0]       gap_cnt_q;

    logic [IDW-1:0]   winner_s;
    logic             found_s;
    logic [IDW:0]     sum_s;
    logic [IDW-1:0]   cand_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             accept_s;
    logic [7:0]       win_data_s;

    // Round-robin search: first valid requester after the last grant, with wrap.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        sum_s    = '0;
        cand_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s  = {1'b0, last_q} + (IDW + 1)'(i) + {{IDW{1'b0}}, 1'b1};
            cand_s = (sum_s >= N_W) ? IDW'(sum_s - N_W) : IDW'(sum_s);
            if (!found_s && i_req_valid[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept strobe: only in IDLE with the transmitter quiet and a winner present.
    always_comb begin
        if (state_q == S_IDLE && !i_tx_busy && found_s) begin
            req_ready_s = ONE_HOT << winner_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign accept_s   = |(req_ready_s & i_req_valid);
    assign win_data_s = i_req_data[{winner_s, 3'b000} +: 8];

    // Frame sequencer: accept, start pulse, busy tracking with timeout, idle gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_INIT;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            gap_cnt_q  <= 8'd0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        tx_data_q  <= win_data_s;
                        grant_q    <= winner_s;
                        last_q     <= winner_s;
                        tx_start_q <= 1'b1;
                        active_q   <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt_q <= TMO_INIT;
                    state_q   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_cnt_q <= 8'd1) begin
                        // Busy never rose: flag it and keep serving requesters.
                        tmo_cnt_q <= 8'd0;
                        err_q     <= 1'b1;
                        gap_cnt_q <= GAP_INIT;
                        state_q   <= S_GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        gap_cnt_q <= GAP_INIT;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    // A zero gap still spends one cycle here.
                    if (gap_cnt_q <= 8'd1) begin
                        gap_cnt_q <= 8'd0;
                        active_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_s;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_grant_id  = grant_q;
    assign o_active    = active_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// run against a round-robin/timing reference model and a transmitter model.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int G    = 1;
    localparam int BT   = 4;
    localparam int IDW  = 2;
    localparam int GAPE = (G == 0) ? 1 : G;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [N-1:0]     i_req_valid;
    logic [8*N-1:0]   i_req_data;
    logic [N-1:0]     o_req_ready;
    logic             o_tx_start;
    logic [7:0]       o_tx_data;
    logic             i_tx_busy;
    logic [IDW-1:0]   o_grant_id;
    logic             o_active;
    logic             o_err;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .BUSY_TIMEOUT(BT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_tx_start(o_tx_start),
        .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id),
        .o_active(o_active), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // values sampled at the falling edge of each cycle
    logic [N-1:0]   s_ready, s_valid;
    logic [8*N-1:0] s_din;
    logic           s_start, s_active, s_err, s_busy;
    logic [7:0]     s_data;
    logic [IDW-1:0] s_grant;
    int             s_cyc;
    bit             acc;
    int             acc_id;
    bit             prev_start;

    // transmitter model: busy rises tx_dly cycles after the pulse, lasts tx_len
    bit tx_auto;
    int tx_dly, tx_len, tx_lead, tx_rem;
    logic [7:0] rx_data_q[$];
    int         rx_id_q[$];

    // reference model state
    bit         model_en, in_frame, seen_busy, pend_start, exp_acc;
    int         m_last, next_ok, exp_id;
    logic [7:0] exp_data;

    function automatic int rr(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic cycle();
        @(negedge i_clk);
        s_ready = o_req_ready; s_valid = i_req_valid; s_din = i_req_data;
        s_start = o_tx_start;  s_data = o_tx_data;    s_grant = o_grant_id;
        s_active = o_active;   s_err = o_err;         s_busy = i_tx_busy;
        s_cyc = cyc;
        acc = |(s_ready & s_valid);
        acc_id = -1;
        for (int k = 0; k < N; k++) if (s_ready[k]) acc_id = k;
        n_checks++;
        if ($countones(s_ready) > 1) $display("FAIL ready_onehot: got %b at cycle %0d", s_ready, s_cyc);
        else n_pass++;
        n_checks++;
        if (s_start && prev_start) $display("FAIL start_twice: got 1 expected 0 at cycle %0d", s_cyc);
        else n_pass++;
        prev_start = s_start;
        if (s_start) begin
            rx_data_q.push_back(s_data);
            rx_id_q.push_back(int'(s_grant));
            if (tx_auto) begin tx_lead = tx_dly + 1; tx_rem = tx_len; end
        end
        if (model_en) begin
            n_checks++;
            if (s_start !== pend_start) $display("FAIL model_start: got %0b expected %0b at cycle %0d", s_start, pend_start, s_cyc);
            else n_pass++;
            if (pend_start && s_start) begin
                n_checks++;
                if (s_data !== exp_data || s_grant !== IDW'(exp_id))
                    $display("FAIL model_byte: got id %0d data %h expected id %0d data %h", s_grant, s_data, exp_id, exp_data);
                else n_pass++;
            end
            pend_start = 1'b0;
            if (in_frame && s_busy) seen_busy = 1'b1;
            exp_acc = !in_frame && (s_cyc >= next_ok) && !s_busy && (s_valid != '0);
            n_checks++;
            if (acc !== exp_acc) $display("FAIL model_accept: got %0b expected %0b at cycle %0d", acc, exp_acc, s_cyc);
            else n_pass++;
            if (exp_acc) begin
                exp_id = rr(m_last, s_valid);
                n_checks++;
                if (acc_id != exp_id) $display("FAIL model_winner: got %0d expected %0d", acc_id, exp_id);
                else n_pass++;
                m_last = exp_id; exp_data = s_din[8*exp_id +: 8];
                pend_start = 1'b1; in_frame = 1'b1; seen_busy = 1'b0;
            end else if (in_frame && seen_busy && !s_busy) begin
                in_frame = 1'b0;
                next_ok = s_cyc + GAPE + 1;
            end
        end
        @(posedge i_clk); #1;
        cyc++;
        if (tx_auto) begin
            if (tx_lead > 0) tx_lead--;
            if (tx_lead == 0 && tx_rem > 0) begin i_tx_busy = 1'b1; tx_rem--; end
            else i_tx_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_req_valid = '0; i_req_data = '0; i_tx_busy = 1'b0;
        tx_auto = 1'b0; tx_lead = 0; tx_rem = 0; tx_dly = 0; tx_len = 1;
        model_en = 1'b0; in_frame = 1'b0; seen_busy = 1'b0; pend_start = 1'b0;
        m_last = N - 1; next_ok = 0; prev_start = 1'b0;
        cycle(); cycle();
        i_rst_n = 1'b1;
        rx_data_q.delete(); rx_id_q.delete();
    endtask

    task automatic wait_idle(input int bound);
        int c;
        c = 0;
        do begin cycle(); c++; end while ((s_active || s_busy) && c < bound);
        n_checks++;
        if (s_active || s_busy) $display("FAIL idle_timeout: active %0b busy %0b after %0d cycles", s_active, s_busy, c);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 6;
        if (s_ready !== 4'b0000) $display("FAIL rst_ready: got %b expected 0000", s_ready); else n_pass++;
        if (s_start !== 1'b0)    $display("FAIL rst_start: got %b expected 0", s_start); else n_pass++;
        if (s_data !== 8'h00)    $display("FAIL rst_data: got %h expected 00", s_data); else n_pass++;
        if (s_grant !== 2'd0)    $display("FAIL rst_grant: got %0d expected 0", s_grant); else n_pass++;
        if (s_active !== 1'b0)   $display("FAIL rst_active: got %b expected 0", s_active); else n_pass++;
        if (s_err !== 1'b0)      $display("FAIL rst_err: got %b expected 0", s_err); else n_pass++;
    endtask

    task automatic test_single();
        int b, f;
        bit seen;
        do_reset();
        tx_auto = 1'b1; tx_dly = 0; tx_len = 6;
        i_req_data = {8'h5A, 8'h5A, 8'hA5, 8'h5A};
        i_req_valid = 4'b0010;
        cycle();
        n_checks++;
        if (s_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", s_ready); else n_pass++;
        i_req_valid = 4'b0000;
        cycle();
        n_checks += 4;
        if (s_start !== 1'b1)  $display("FAIL single_start: got %b expected 1", s_start); else n_pass++;
        if (s_data !== 8'hA5)  $display("FAIL single_data: got %h expected a5", s_data); else n_pass++;
        if (s_grant !== 2'd1)  $display("FAIL single_grant: got %0d expected 1", s_grant); else n_pass++;
        if (s_active !== 1'b1) $display("FAIL single_active: got %b expected 1", s_active); else n_pass++;
        b = -1; f = -1; seen = 1'b0;
        for (int c = 0; c < 60 && f < 0; c++) begin
            cycle();
            if (s_busy) seen = 1'b1;
            if (seen && !s_busy && b < 0) b = s_cyc;
            if (b >= 0 && !s_active) f = s_cyc;
        end
        n_checks += 2;
        if (b < 0 || f < 0 || (f - b) != GAPE + 1) $display("FAIL single_active_fall: got %0d expected %0d", f - b, GAPE + 1); else n_pass++;
        if (s_data !== 8'hA5) $display("FAIL single_data_hold: got %h expected a5", s_data); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b [5];
        int exp_i [5];
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_i = '{0, 1, 2, 3, 0};
        do_reset();
        tx_auto = 1'b1; tx_dly = 0; tx_len = 8; model_en = 1'b1;
        i_req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        i_req_valid = 4'b1111;
        for (int c = 0; c < 400 && rx_data_q.size() < 5; c++) cycle();
        i_req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= rx_data_q.size()) $display("FAIL rr_missing: got %0d frames expected 5", rx_data_q.size());
            else if (rx_data_q[i] !== exp_b[i] || rx_id_q[i] != exp_i[i])
                $display("FAIL rr_order: frame %0d got id %0d data %h expected id %0d data %h", i, rx_id_q[i], rx_data_q[i], exp_i[i], exp_b[i]);
            else n_pass++;
        end
        wait_idle(60);
        model_en = 1'b0;
    endtask

    task automatic test_timeout();
        int s;
        bit got;
        do_reset();
        i_req_data = {8'h00, 8'h7E, 8'h00, 8'h42};
        i_req_valid = 4'b0100;
        s = -1;
        for (int c = 0; c < 20 && s < 0; c++) begin
            cycle();
            if (acc) i_req_valid = 4'b0000;
            if (s_start) s = s_cyc;
        end
        n_checks++;
        if (s < 0) $display("FAIL tmo_no_start: got none expected a start pulse"); else n_pass++;
        for (int j = 0; j < BT; j++) cycle();
        n_checks += 2;
        if (s_err !== 1'b0) $display("FAIL tmo_err_early: got %b expected 0 at cycle %0d", s_err, s_cyc); else n_pass++;
        cycle();
        if (s_err !== 1'b1) $display("FAIL tmo_err_set: got %b expected 1 at cycle %0d", s_err, s_cyc); else n_pass++;
        i_req_valid = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cycle();
            got = acc;
        end
        n_checks++;
        if (!got || acc_id != 0) $display("FAIL tmo_next_grant: got %0d expected 0", acc_id); else n_pass++;
        i_req_valid = 4'b0000;
        cycle();
        n_checks += 2;
        if (s_start !== 1'b1 || s_data !== 8'h42) $display("FAIL tmo_next_start: got %b/%h expected 1/42", s_start, s_data); else n_pass++;
        if (s_err !== 1'b1) $display("FAIL tmo_err_sticky: got %b expected 1", s_err); else n_pass++;
        wait_idle(40);
    endtask

    task automatic test_fair_wrap();
        bit got;
        do_reset();
        tx_auto = 1'b1; tx_dly = 1; tx_len = 4;
        i_req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        i_req_valid = 4'b1000;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin cycle(); got = acc; end
        n_checks++;
        if (!got || acc_id != 3) $display("FAIL wrap_first: got %0d expected 3", acc_id); else n_pass++;
        i_req_valid = 4'b1001;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin cycle(); got = acc; end
        n_checks++;
        if (!got || acc_id != 0) $display("FAIL wrap_second: got %0d expected 0", acc_id); else n_pass++;
        i_req_valid = 4'b0000;
        wait_idle(40);
    endtask

    task automatic test_busy_idle();
        do_reset();
        i_tx_busy = 1'b1;
        i_req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
        i_req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks++;
            if (s_ready !== 4'b0000 || s_start !== 1'b0) $display("FAIL busy_idle_block: got ready %b start %b expected 0000 0", s_ready, s_start);
            else n_pass++;
        end
        i_tx_busy = 1'b0;
        cycle();
        n_checks++;
        if (s_ready !== 4'b0001) $display("FAIL busy_idle_grant: got %b expected 0001", s_ready); else n_pass++;
        i_req_valid = 4'b0000;
        cycle();
        n_checks++;
        if (s_start !== 1'b1 || s_data !== 8'h3C || s_grant !== 2'd0)
            $display("FAIL busy_idle_start: got %b/%h/%0d expected 1/3c/0", s_start, s_data, s_grant);
        else n_pass++;
        i_tx_busy = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        i_tx_busy = 1'b0;
        wait_idle(20);
        n_checks++;
        if (s_err !== 1'b0) $display("FAIL busy_idle_err: got %b expected 0", s_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ns;
        bit got;
        do_reset();
        tx_auto = 1'b1; tx_dly = 0; tx_len = 40;
        i_req_data = {8'h00, 8'h00, 8'h00, 8'hC3};
        i_req_valid = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin cycle(); got = acc; end
        i_req_valid = 4'b0000;
        for (int c = 0; c < 10 && !s_busy; c++) cycle();
        for (int c = 0; c < 3; c++) cycle();
        n_checks++;
        if (!(s_busy && s_active && s_data === 8'hC3)) $display("FAIL mid_setup: got busy %b active %b data %h", s_busy, s_active, s_data);
        else n_pass++;
        i_rst_n = 1'b0; tx_auto = 1'b0; tx_rem = 0; tx_lead = 0; i_tx_busy = 1'b0;
        #1;
        n_checks += 4;
        if (o_tx_data !== 8'h00)   $display("FAIL mid_rst_data: got %h expected 00", o_tx_data); else n_pass++;
        if (o_active !== 1'b0)     $display("FAIL mid_rst_active: got %b expected 0", o_active); else n_pass++;
        if (o_tx_start !== 1'b0)   $display("FAIL mid_rst_start: got %b expected 0", o_tx_start); else n_pass++;
        if (o_req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", o_req_ready); else n_pass++;
        cycle(); cycle();
        i_rst_n = 1'b1;
        ns = 0;
        for (int c = 0; c < 10; c++) begin cycle(); if (s_start) ns++; end
        n_checks++;
        if (ns != 0) $display("FAIL mid_no_start: got %0d pulses expected 0", ns); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] buf_d [N][8];
        int head [N];
        int tail [N];
        int total, served;
        do_reset();
        tx_auto = 1'b1; model_en = 1'b1;
        total = 0; served = 0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = int'($urandom_range(2, 6));
            for (int j = 0; j < 8; j++) buf_d[k][j] = 8'($urandom);
            total += tail[k];
        end
        for (int c = 0; c < 3000 && served < total; c++) begin
            for (int k = 0; k < N; k++) begin
                i_req_valid[k] = (head[k] < tail[k]);
                i_req_data[8*k +: 8] = (head[k] < tail[k]) ? buf_d[k][head[k]] : 8'h00;
            end
            tx_dly = int'($urandom_range(0, BT - 1));
            tx_len = int'($urandom_range(1, 10));
            cycle();
            if (acc && acc_id >= 0) begin head[acc_id]++; served++; end
        end
        i_req_valid = '0;
        wait_idle(60);
        n_checks += 2;
        if (served != total) $display("FAIL rand_served: got %0d expected %0d", served, total); else n_pass++;
        if (rx_data_q.size() != total) $display("FAIL rand_frames: got %0d expected %0d", rx_data_q.size(), total); else n_pass++;
        model_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_fair_wrap();
        test_busy_idle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
